seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Time-multiplexed scan controller for the 8-digit, common-anode 7-segment display. It holds one 4-bit hex value per digit, generates the digit index and the active-low digit select, and drives the active-low segment lines. Dead time at each digit change suppresses ghosting. It is the producing end of the digit-select interface: it sources `num` and the matching `sel` and `seg` that the board display consumes.

## Interface
Parameters:
- `SCAN_DIV`, default 100000: clock cycles per digit slot, minimum 4. At 100 MHz this gives 1 kHz per digit.
- `DEAD_CYC`, default 1000: cycles at the start of each slot with `sel` forced to all 1s. Must satisfy 0 ≤ `DEAD_CYC` < `SCAN_DIV`.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  synchronous reset, active-high.
- `power_led`  in  1  display enable. 0 means dark and scan held.
- `wr_en`  in  1  digit register write strobe, sampled on the rising edge of `clk`.
- `wr_addr`  in  3  digit index to write, 0–7.
- `wr_data`  in  4  hex value to write.
- `blank_mask`  in  8  bit i = 1 keeps digit i dark.
- `num`  out  3  current digit index, 0–7.
- `sel`  out  8  digit select, active low. Bit i low means digit i is lit.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active low.
- `dp`  out  1  decimal point, active low. Used only with `SEG_DP_EN`.

## Operation
- Storage: eight 4-bit digit registers, `dig[0..7]`.
  - Writes occur when `wr_en`=1 and are accepted regardless of `power_led`.
- Counters:
  - Prescaler `pc` counts 0 … `SCAN_DIV`−1.
  - At `pc` = `SCAN_DIV`−1, `pc` returns to 0 and `num` increments. `num` wraps from 7 to 0.
- Slot behaviour:
  - Dead phase: while `pc` < `DEAD_CYC`, `sel` = 8'hFF.
  - Lit phase: otherwise, `sel` = ~(1 << `num`). If `blank_mask[num]` = 1, `sel` = 8'hFF instead.
- Segment decode: `seg` = hex glyph of `dig[num]`.
  - 0 → 7'b1000000, 1 → 7'b1111001, 8 → 7'b0000000, A → 7'b0001000, F → 7'b0001110.
  - The remaining values use the standard hex glyphs.
- `power_led` = 0:
  - `pc` and `num` are cleared and held at 0.
  - `sel` = 8'hFF, `seg` = 7'h7F, `dp` = 1.
- `power_led` 0→1: the scan starts from `num` = 0 with `pc` = 0, so the first cycles form a dead phase.

## Timing
- Reset values: `num`=0, `pc`=0, `sel`=8'hFF, `seg`=7'h7F, `dp`=1, all `dig`=0.
- Output registers:
  - `sel`, `seg` and `dp` are registered. They reflect the `num`/`pc`/`dig`/`blank_mask`/`power_led` state of the previous cycle, i.e. 1-cycle latency.
  - `num` is a direct register output, with no extra stage.
- Write visibility: a write to the digit currently displayed changes `seg` 2 edges after the `wr_en` edge. The write lands in `dig` at edge N, and `seg` updates at edge N+1.
- Slot period: every slot is exactly `SCAN_DIV` cycles. A full frame is 8×`SCAN_DIV` cycles.
- Boundary cases:
  - Simultaneous `rst` and `wr_en`: reset wins and no write occurs.
  - `rst` mid-slot: all outputs return to their reset values on the next edge.
  - `blank_mask` change mid-slot: takes effect with the normal 1-cycle latency and does not disturb `pc` or `num`.
  - `DEAD_CYC` = 0: there is no dead phase. `sel` switches directly between adjacent digits.

## Configuration
- Macro `SEG_DP_EN`.
  - When defined: adds input `wr_dp` (1 bit), which is stored per digit on a write. `dp` = ~`dp_reg[num]` during the lit phase of an unblanked digit, and 1 otherwise, with the same latency as `seg`.
  - When undefined: there is no `wr_dp` port and `dp` is tied to 1.

## Test plan
The bench uses `SCAN_DIV`=4 and `DEAD_CYC`=1.
- Reset: assert `rst` for 2 cycles → `sel`=FF, `seg`=7F, `num`=0, `dp`=1.
- Full scan:
  - Stimulus: write `dig[i]`=i for i=0..7, then set `power_led`=1.
  - Response: `num` steps 0→7→0 every 4 cycles. In each slot `sel` is FF for 1 cycle, then ~(1<<i) for 3 cycles. `seg` shows 1000000 for digit 0 and 0000000 for digit 8's value… i.e. 0000000 when the digit holds 8.
- Blanking: `blank_mask`=8'h04 → `sel` stays FF throughout slot 2, and all other slots are unchanged.
- Power-off:
  - Drop `power_led` at `num`=5 → the next edge gives `sel`=FF and `seg`=7F, with `num` held at 0.
  - Re-raise `power_led` → the scan restarts at digit 0.
- Live write: write F to the digit currently displayed mid-lit-phase → `seg`=0001110 two edges later, and the slot length is unchanged.
- `SEG_DP_EN` build: write digit 3 with `wr_dp`=1 → `dp`=0 only during the lit phase of slot 3.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for an 8-digit common-anode 7-segment display.
// Optional per-digit decimal point storage is enabled by defining SEG_DP_EN.
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned DEAD_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_led,
    input  logic       wr_en,
`ifdef SEG_DP_EN
    input  logic       wr_dp,
`endif
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [7:0] blank_mask,
    output logic [2:0] num,
    output logic [7:0] sel,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned PcW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PcW-1:0] PcMax = PcW'(SCAN_DIV - 1);

    logic [7:0][3:0] dig_q, dig_d;
    logic [PcW-1:0]  pc_q, pc_d;
    logic [2:0]      num_q, num_d;
    logic [7:0]      sel_q, sel_d;
    logic [6:0]      seg_q, seg_d;
    logic [31:0]     pc_ext;
    logic            dead;
    logic            lit;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        unique case (v)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            4'hF: g = 7'b0001110;
        endcase
        return g;
    endfunction

    always_comb begin
        dig_d = dig_q;
        if (wr_en) begin
            dig_d[wr_addr] = wr_data;
        end

        // Display off holds the scan at the start of slot 0.
        pc_d  = '0;
        num_d = '0;
        if (power_led) begin
            if (pc_q == PcMax) begin
                num_d = num_q + 3'd1;
            end else begin
                pc_d  = pc_q + 1'b1;
                num_d = num_q;
            end
        end

        pc_ext = 32'(pc_q);
        dead   = pc_ext < DEAD_CYC;
        lit    = power_led && !dead && !blank_mask[num_q];

        sel_d = lit ? ~(8'h01 << num_q) : 8'hFF;
        seg_d = power_led ? hex_glyph(dig_q[num_q]) : 7'h7F;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_q <= '0;
            pc_q  <= '0;
            num_q <= '0;
            sel_q <= 8'hFF;
            seg_q <= 7'h7F;
        end else begin
            dig_q <= dig_d;
            pc_q  <= pc_d;
            num_q <= num_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
        end
    end

`ifdef SEG_DP_EN
    logic [7:0] dp_reg_q, dp_reg_d;
    logic       dp_q, dp_d;

    always_comb begin
        dp_reg_d = dp_reg_q;
        if (wr_en) begin
            dp_reg_d[wr_addr] = wr_dp;
        end
        dp_d = ~(lit && dp_reg_q[num_q]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_reg_q <= '0;
            dp_q     <= 1'b1;
        end else begin
            dp_reg_q <= dp_reg_d;
            dp_q     <= dp_d;
        end
    end

    assign dp = dp_q;
`else
    assign dp = 1'b1;
`endif

    assign num = num_q;
    assign sel = sel_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, DEAD_CYC=1.
// Define SEG_DP_EN to also exercise the decimal-point path.
module tb_seg_scan_driver;

    logic       clk;
    logic       rst;
    logic       power_led;
    logic       wr_en;
`ifdef SEG_DP_EN
    logic       wr_dp;
`endif
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [7:0] blank_mask;
    logic [2:0] num;
    logic [7:0] sel;
    logic [6:0] seg;
    logic       dp;

    int n_err = 0;
    int n_chk = 0;
    int k     = 0;

    logic [3:0] mdig [8];
    logic       mdp  [8];

    // Active-low {g,f,e,d,c,b,a} glyphs for 0..F.
    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg_scan_driver #(
        .SCAN_DIV (4),
        .DEAD_CYC (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .power_led  (power_led),
        .wr_en      (wr_en),
`ifdef SEG_DP_EN
        .wr_dp      (wr_dp),
`endif
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .blank_mask (blank_mask),
        .num        (num),
        .sel        (sel),
        .seg        (seg),
        .dp         (dp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_sel"}, 32'(sel), 32'h0FF);
        chk({tag, "_seg"}, 32'(seg), 32'h07F);
        chk({tag, "_num"}, 32'(num), 32'h0);
        chk({tag, "_dp"},  32'(dp),  32'h1);
    endtask

    // k counts edges since the scan started from pc=0, num=0.
    task automatic step_chk(input string tag);
        int         s;
        int         p;
        logic       lit;
        logic [7:0] esel;
        logic [7:0] one;
        logic       edp;
        tick();
        k++;
        s   = ((k - 1) / 4) % 8;
        p   = (k - 1) % 4;
        lit = (p != 0) && !blank_mask[s];
        one = 8'h01;
        esel = lit ? ~(one << s) : 8'hFF;
        edp = 1'b1;
`ifdef SEG_DP_EN
        if (lit && mdp[s]) edp = 1'b0;
`endif
        chk({tag, "_sel"}, 32'(sel), 32'(esel));
        chk({tag, "_seg"}, 32'(seg), 32'(glyph[mdig[s]]));
        chk({tag, "_num"}, 32'((k / 4) % 8), 32'(num));
        chk({tag, "_dp"},  32'(dp),  32'(edp));
    endtask

    initial begin
        int s;
        for (int i = 0; i < 8; i++) begin
            mdig[i] = 4'h0;
            mdp[i]  = 1'b0;
        end

        // Reset held with a competing write to digit 0: reset must win.
        rst        = 1'b1;
        power_led  = 1'b0;
        wr_en      = 1'b1;
        wr_addr    = 3'd0;
        wr_data    = 4'h9;
        blank_mask = 8'h00;
`ifdef SEG_DP_EN
        wr_dp      = 1'b1;
`endif
        tick();
        tick();
        chk_dark("reset");
        rst   = 1'b0;
        wr_en = 1'b0;

        // Load digits 1..7 with power off; digit 0 keeps its reset value.
        for (int i = 1; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_data = 4'(i);
`ifdef SEG_DP_EN
            wr_dp   = (i == 3);
            mdp[i]  = (i == 3);
`endif
            tick();
            mdig[i] = 4'(i);
        end
        wr_en = 1'b0;
`ifdef SEG_DP_EN
        wr_dp = 1'b0;
`endif
        chk_dark("off_load");

        power_led = 1'b1;
        k = 0;
        repeat (36) step_chk("scan");

        blank_mask = 8'h04;
        repeat (32) step_chk("blank");
        blank_mask = 8'h00;

        // Live write of F into the digit in its first lit cycle.
        while (((k - 1) % 4) != 1) step_chk("pre_wr");
        s       = ((k - 1) / 4) % 8;
        wr_en   = 1'b1;
        wr_addr = 3'(s);
        wr_data = 4'hF;
        step_chk("wr_land");
        mdig[s] = 4'hF;
        wr_en   = 1'b0;
        step_chk("wr_vis");
        chk("wr_seg", 32'(seg), 32'h0E);
        repeat (8) step_chk("wr_after");

        // Power off mid-slot 5, then restart.
        while (((k / 4) % 8) != 5) step_chk("pre_off");
        step_chk("pre_off");
        power_led = 1'b0;
        tick();
        chk_dark("off");
        repeat (3) tick();
        chk_dark("off_hold");
        power_led = 1'b1;
        k = 0;
        repeat (12) step_chk("restart");

        // Reset mid-lit-phase clears outputs and digit storage.
        while (((k - 1) % 4) != 2) step_chk("pre_rst");
        rst = 1'b1;
        tick();
        chk_dark("mid_rst");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mdig[i] = 4'h0;
            mdp[i]  = 1'b0;
        end
        k = 0;
        repeat (8) step_chk("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
